// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - 32-bit EX-stage ALU with registered result and branch-taken flag.
// Optional macro ALU_VAR_SHIFT_EN enables R-type SLLV/SRLV/SRAV (count from rs[4:0]).
`timescale 1ns/1ps
module alu_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  opcode,
   input  logic [31:0] rs_content,
   input  logic [31:0] rt_content,
   input  logic [4:0]  shamt,
   input  logic [5:0]  ALU_control,
   input  logic [15:0] immediate,
   output logic [31:0] ALU_result,
   output logic        sig_branch
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b010000;
   localparam logic [5:0] OP_ANDI  = 6'b010010;
   localparam logic [5:0] OP_ORI   = 6'b010011;
   localparam logic [5:0] OP_XORI  = 6'b010100;
   localparam logic [5:0] OP_SLTI  = 6'b010101;
   localparam logic [5:0] OP_LUI   = 6'b010110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_XOR   = 6'b100110;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLTU  = 6'b101011;
   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_SRA   = 6'b000011;
`ifdef ALU_VAR_SHIFT_EN
   localparam logic [5:0] FN_SLLV  = 6'b000100;
   localparam logic [5:0] FN_SRLV  = 6'b000110;
   localparam logic [5:0] FN_SRAV  = 6'b000111;
`endif

   logic [31:0] w_sext;
   logic [31:0] w_zext;
   logic [31:0] w_diff;
   logic [31:0] w_result;
   logic        w_branch;
   logic [31:0] r_result;
   logic        r_branch;

   assign w_sext = {{16{immediate[15]}}, immediate};
   assign w_zext = {16'b0, immediate};
   // Shared by SUB and both branches so the compare reuses one subtractor
   assign w_diff = rs_content - rt_content;

   always_comb begin
      w_result = 32'b0;
      w_branch = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (ALU_control)
               FN_ADD:  w_result = rs_content + rt_content;
               FN_SUB:  w_result = w_diff;
               FN_AND:  w_result = rs_content & rt_content;
               FN_OR:   w_result = rs_content | rt_content;
               FN_XOR:  w_result = rs_content ^ rt_content;
               FN_NOR:  w_result = ~(rs_content | rt_content);
               FN_SLT:  w_result = {31'b0, $signed(rs_content) < $signed(rt_content)};
               FN_SLTU: w_result = {31'b0, rs_content < rt_content};
               FN_SLL:  w_result = rt_content << shamt;
               FN_SRL:  w_result = rt_content >> shamt;
               FN_SRA:  w_result = $unsigned($signed(rt_content) >>> shamt);
`ifdef ALU_VAR_SHIFT_EN
               FN_SLLV: w_result = rt_content << rs_content[4:0];
               FN_SRLV: w_result = rt_content >> rs_content[4:0];
               FN_SRAV: w_result = $unsigned($signed(rt_content) >>> rs_content[4:0]);
`endif
               default: w_result = 32'b0;
            endcase
         end
         OP_ADDI: w_result = rs_content + w_sext;
         OP_ANDI: w_result = rs_content & w_zext;
         OP_ORI:  w_result = rs_content | w_zext;
         OP_XORI: w_result = rs_content ^ w_zext;
         OP_SLTI: w_result = {31'b0, $signed(rs_content) < $signed(w_sext)};
         OP_LUI:  w_result = {immediate, 16'b0};
         OP_LW,
         OP_SW:   w_result = rs_content + w_sext;
         OP_BEQ: begin
            w_result = w_diff;
            w_branch = (w_diff == 32'b0);
         end
         OP_BNE: begin
            w_result = w_diff;
            w_branch = (w_diff != 32'b0);
         end
         default: begin
            w_result = 32'b0;
            w_branch = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result <= 32'b0;
         r_branch <= 1'b0;
      end else begin
         r_result <= w_result;
         r_branch <= w_branch;
      end
   end

   assign ALU_result = r_result;
   assign sig_branch = r_branch;

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - scoreboard bench for alu_unit: directed and random ops vs. a reference model.
`timescale 1ns/1ps
module tb_alu_unit;

   logic        clk = 1'b0;
   logic        clk_en = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  opcode = '0;
   logic [31:0] rs_content = '0;
   logic [31:0] rt_content = '0;
   logic [4:0]  shamt = '0;
   logic [5:0]  ALU_control = '0;
   logic [15:0] immediate = '0;
   logic [31:0] ALU_result;
   logic        sig_branch;

   typedef struct {
      logic [31:0] res;
      logic        br;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   logic [5:0] op_tab [0:15];
   logic [5:0] fn_tab [0:15];

   alu_unit dut (
      .clk(clk), .rst(rst), .opcode(opcode), .rs_content(rs_content),
      .rt_content(rt_content), .shamt(shamt), .ALU_control(ALU_control),
      .immediate(immediate), .ALU_result(ALU_result), .sig_branch(sig_branch)
   );

   always #5 if (clk_en) clk = ~clk;

   task automatic check(input string name, input logic [31:0] gr, input logic gb,
                        input logic [31:0] er, input logic eb);
      n_cmp++;
      if (gr !== er || gb !== eb) begin
         n_err++;
         $display("FAIL %s: got result=%h branch=%b, expected result=%h branch=%b",
                  name, gr, gb, er, eb);
      end
   endtask

   function automatic logic [31:0] sra_ref(input logic [31:0] v, input int n);
      logic [31:0] r;
      r = v >> n;
      if (v[31]) r = r | ~(32'hFFFF_FFFF >> n);
      return r;
   endfunction

   function automatic logic lt_signed(input logic [31:0] a, input logic [31:0] b);
      return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
   endfunction

   function automatic void model(input logic [5:0] op, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, input logic [15:0] imm,
                                 output logic [31:0] r, output logic br);
      logic [31:0] se;
      logic [31:0] ze;
      se = {{16{imm[15]}}, imm};
      ze = {16'h0000, imm};
      r  = 32'h0;
      br = 1'b0;
      if (op == 6'b000000) begin
         if      (fn == 6'b100000) r = a + b;
         else if (fn == 6'b100010) r = a - b;
         else if (fn == 6'b100100) r = a & b;
         else if (fn == 6'b100101) r = a | b;
         else if (fn == 6'b100110) r = a ^ b;
         else if (fn == 6'b100111) r = ~(a | b);
         else if (fn == 6'b101010) r = {31'h0, lt_signed(a, b)};
         else if (fn == 6'b101011) r = {31'h0, a < b};
         else if (fn == 6'b000000) r = b << sh;
         else if (fn == 6'b000010) r = b >> sh;
         else if (fn == 6'b000011) r = sra_ref(b, int'(sh));
`ifdef ALU_VAR_SHIFT_EN
         else if (fn == 6'b000100) r = b << a[4:0];
         else if (fn == 6'b000110) r = b >> a[4:0];
         else if (fn == 6'b000111) r = sra_ref(b, int'(a[4:0]));
`endif
      end
      else if (op == 6'b010000 || op == 6'b100011 || op == 6'b101011) r = a + se;
      else if (op == 6'b010010) r = a & ze;
      else if (op == 6'b010011) r = a | ze;
      else if (op == 6'b010100) r = a ^ ze;
      else if (op == 6'b010101) r = {31'h0, lt_signed(a, se)};
      else if (op == 6'b010110) r = {imm, 16'h0000};
      else if (op == 6'b000100) begin r = a - b; br = (a == b); end
      else if (op == 6'b000101) begin r = a - b; br = (a != b); end
   endfunction

   task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [15:0] imm,
                        input string name);
      exp_t e;
      @(negedge clk);
      rst = 1'b0;
      opcode = op; ALU_control = fn; rs_content = a; rt_content = b;
      shamt = sh; immediate = imm;
      model(op, fn, a, b, sh, imm, e.res, e.br);
      e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic randomize_inputs();
      opcode = 6'($urandom); ALU_control = 6'($urandom);
      rs_content = $urandom; rt_content = $urandom;
      shamt = 5'($urandom); immediate = 16'($urandom);
   endtask

   task automatic issue_rst(input string name);
      exp_t e;
      @(negedge clk);
      rst = 1'b1;
      randomize_inputs();
      e.res = 32'h0; e.br = 1'b0; e.name = name;
      exp_q.push_back(e);
   endtask

   // Monitor: outputs settle one cycle after issue; compare just after each rising edge
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(e.name, ALU_result, sig_branch, e.res, e.br);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      op_tab = '{6'b000000, 6'b000000, 6'b000000, 6'b000100, 6'b000101, 6'b010000,
                 6'b010010, 6'b010011, 6'b010100, 6'b010101, 6'b010110, 6'b100011,
                 6'b101011, 6'b111111, 6'b000001, 6'b001111};
      fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                 6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b000011, 6'b000100,
                 6'b000110, 6'b000111, 6'b111111, 6'b100001};

      // Reset with the clock stopped
      rst = 1'b1;
      randomize_inputs();
      #3;
      check("rst_noclk_a", ALU_result, sig_branch, 32'h0, 1'b0);
      randomize_inputs();
      #3;
      check("rst_noclk_b", ALU_result, sig_branch, 32'h0, 1'b0);

      clk_en = 1'b1;
      for (int i = 0; i < 4; i++) issue_rst("rst_clk");

      issue(6'b010011, 6'h00, 32'h9, 32'h0, 5'd0, 16'h0009, "ori_9_9");
      issue(6'b010011, 6'h00, 32'hE, 32'h0, 5'd0, 16'h000F, "ori_e_f");
      issue(6'b010011, 6'h00, 32'h1, 32'h0, 5'd0, 16'h0008, "ori_1_8");
      issue(6'b010011, 6'h00, 32'h0, 32'h0, 5'd0, 16'h8000, "ori_zext");
      issue(6'b000000, 6'b100000, 32'hFFFF_FFFF, 32'h1, 5'd0, 16'h0, "add_wrap");
      issue(6'b000000, 6'b100010, 32'd3, 32'd5, 5'd0, 16'h0, "sub_neg");
      issue(6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'h1, 5'd0, 16'h0, "slt_signed");
      issue(6'b000000, 6'b101011, 32'hFFFF_FFFF, 32'h1, 5'd0, 16'h0, "sltu_unsigned");
      issue(6'b000000, 6'b000011, 32'h0, 32'h8000_0000, 5'd4, 16'h0, "sra_4");
      issue(6'b000000, 6'b000010, 32'h0, 32'h8000_0000, 5'd4, 16'h0, "srl_4");
      issue(6'b000000, 6'b000000, 32'h0, 32'h1, 5'd31, 16'h0, "sll_31");
      issue(6'b000000, 6'b000011, 32'h0, 32'h8765_4321, 5'd0, 16'h0, "sra_0");
      issue(6'b000100, 6'h00, 32'd7, 32'd7, 5'd0, 16'h0, "beq_taken");
      issue(6'b000101, 6'h00, 32'd7, 32'd7, 5'd0, 16'h0, "bne_not_taken");
      issue(6'b000101, 6'h00, 32'd7, 32'd8, 5'd0, 16'h0, "bne_taken");
      issue(6'b010000, 6'h00, 32'd10, 32'h0, 5'd0, 16'hFFFF, "addi_sext");
      issue(6'b010110, 6'h00, 32'h0, 32'h0, 5'd0, 16'h1234, "lui");
      issue(6'b111111, 6'b100000, 32'd7, 32'd7, 5'd0, 16'hFFFF, "illegal_op");
      issue(6'b000000, 6'b000100, 32'd3, 32'h0000_00F0, 5'd0, 16'h0, "sllv_or_unlisted");

      for (int i = 0; i < 300; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         issue(op_tab[$urandom_range(0, 15)], fn_tab[$urandom_range(0, 15)], a, b,
               5'($urandom), 16'($urandom), "random");
      end

      // Asynchronous reset landing mid-cycle must clear held outputs at once
      issue(6'b010011, 6'h00, 32'h9, 32'h0, 5'd0, 16'h0009, "ori_before_rst");
      issue(6'b000100, 6'h00, 32'd5, 32'd5, 5'd0, 16'h0, "beq_before_rst");
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_mid", ALU_result, sig_branch, 32'h0, 1'b0);
      issue(6'b010110, 6'h00, 32'h0, 32'h0, 5'd0, 16'hABCD, "lui_after_rst");
      issue(6'b000000, 6'b100111, 32'h0F0F_0000, 32'h0000_00FF, 5'd0, 16'h0, "nor_after_rst");

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expected results still queued, required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
